uart_rx_ctrl: RTL and testbench

Frame-level controller for the UART receiver. It sequences the existing 3-sample majority-vote data_sampling block by driving its Data_Sample_EN and Edge_Counter inputs and reading back Sampled_bit. It also runs the start/data/parity/stop state machine, deserialises the data LSB-first and checks parity and stop bits. It sits between the RX_IN pin synchroniser and the system-side consumer of P_DATA/data_valid.

---
 rtl/uart_rx_pkg.sv | 30 +++
 rtl/uart_rx_ctrl_if.sv | 25 ++
 rtl/uart_rx_edge_bit_cnt.sv | 29 ++
 rtl/uart_rx_ctrl.sv | 111 +++++++++++
 tb/tb_uart_rx_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller:
// FSM state encoding, legal oversampling ratios and parity types.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic [5:0] PRESC_4   = 6'd4;
  localparam logic [5:0] PRESC_8   = 6'd8;
  localparam logic [5:0] PRESC_16  = 6'd16;
  localparam logic [5:0] PRESC_32  = 6'd32;
  localparam logic [5:0] PRESC_DEF = PRESC_8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Anything other than 4/8/16/32 falls back to the default ratio.
  function automatic logic [5:0] legal_presc(input logic [5:0] p);
    case (p)
      PRESC_4, PRESC_8, PRESC_16, PRESC_32: return p;
      default:                              return PRESC_DEF;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the frame controller (slave) and its surroundings:
// line input, configuration, sampler handshake and received-frame results.
interface uart_rx_ctrl_if #(parameter int DATA_WIDTH = 8);
  logic                  RX_IN;
  logic [5:0]            prescaler;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  Sampled_bit;
  logic                  Data_Sample_EN;
  logic [4:0]            Edge_Counter;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  Parity_Error;
  logic                  Stop_Error;

  modport slave (
    input  RX_IN, prescaler, PAR_EN, PAR_TYP, Sampled_bit,
    output Data_Sample_EN, Edge_Counter, P_DATA, data_valid, Parity_Error, Stop_Error
  );

  modport master (
    output RX_IN, prescaler, PAR_EN, PAR_TYP, Sampled_bit,
    input  Data_Sample_EN, Edge_Counter, P_DATA, data_valid, Parity_Error, Stop_Error
  );
endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter (wraps at last) and data-bit counter,
// each with its own enable and synchronous clear.
module uart_rx_edge_bit_cnt #(
  parameter int BIT_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             edge_en,
  input  logic             edge_clr,
  input  logic [4:0]       last,
  input  logic             bit_en,
  input  logic             bit_clr,
  output logic [4:0]       edge_cnt,
  output logic [BIT_W-1:0] bit_cnt
);

  always_ff @(posedge CLK) begin
    if (!RST)                edge_cnt <= '0;
    else if (edge_clr)       edge_cnt <= '0;
    else if (edge_en)        edge_cnt <= (edge_cnt == last) ? 5'd0 : edge_cnt + 5'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RST)                bit_cnt <= '0;
    else if (bit_clr)        bit_cnt <= '0;
    else if (bit_en)         bit_cnt <= bit_cnt + 1'b1;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: drives the majority-vote sampler, walks
// start/data/parity/stop, deserialises LSB-first and flags parity/stop errors.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic           CLK,
  input  logic           RST,
  uart_rx_ctrl_if.slave  bus
);

  localparam int               BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  rx_state_e             state_q, state_d;
  logic [5:0]            presc_q;
  logic                  par_en_q, par_typ_q;
  logic [4:0]            edge_cnt, mid, cap, last;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  at_cap, at_last;
  logic [DATA_WIDTH-1:0] shift_q, pdata_q;
  logic                  dv_q, perr_q, serr_q;
  logic                  dse, cfg_ld, start_det, edge_clr, bit_en, bit_clr;
  logic                  shift_en, par_chk, stop_chk, frame_ok;

  // Capture edge sits two edges past mid so the sampler's 3-sample vote has settled;
  // at P=4 there is no room for that, so it moves in to edge 2.
  assign mid     = presc_q[5:1];
  assign cap     = (presc_q == PRESC_4) ? 5'd2 : mid + 5'd2;
  assign last    = 5'(presc_q - 6'd1);
  assign at_cap  = (edge_cnt == cap);
  assign at_last = (edge_cnt == last);

  uart_rx_edge_bit_cnt #(.BIT_W(BIT_W)) u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .edge_en  (dse),
    .edge_clr (edge_clr),
    .last     (last),
    .bit_en   (bit_en),
    .bit_clr  (bit_clr),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt)
  );

  always_ff @(posedge CLK) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!bus.RX_IN) state_d = START;
      START:   if (at_cap && bus.Sampled_bit) state_d = IDLE;
               else if (at_last)              state_d = DATA;
      DATA:    if (at_last && bit_cnt == BIT_LAST) state_d = par_en_q ? PARITY : STOP;
      PARITY:  if (at_last) state_d = STOP;
      STOP:    if (at_last) state_d = bus.RX_IN ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dse       = (state_q != IDLE);
    cfg_ld    = (state_q == IDLE) && (state_d == START);
    start_det = (state_q != START) && (state_d == START);
    edge_clr  = (state_d == IDLE);
    bit_clr   = (state_q == START);
    bit_en    = (state_q == DATA) && at_last && (bit_cnt != BIT_LAST);
    shift_en  = (state_q == DATA) && at_cap;
    par_chk   = (state_q == PARITY) && at_cap;
    stop_chk  = (state_q == STOP) && at_cap;
    frame_ok  = (state_q == STOP) && at_last && !perr_q && !serr_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      presc_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      shift_q   <= '0;
      pdata_q   <= '0;
      dv_q      <= 1'b0;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
    end else begin
      if (cfg_ld) begin
        presc_q   <= legal_presc(bus.prescaler);
        par_en_q  <= bus.PAR_EN;
        par_typ_q <= bus.PAR_TYP;
      end
      if (shift_en) shift_q <= {bus.Sampled_bit, shift_q[DATA_WIDTH-1:1]};
      if (start_det)     perr_q <= 1'b0;
      else if (par_chk)  perr_q <= bus.Sampled_bit ^ (^shift_q) ^ par_typ_q;
      if (start_det)     serr_q <= 1'b0;
      else if (stop_chk) serr_q <= ~bus.Sampled_bit;
      dv_q <= frame_ok;
      if (frame_ok) pdata_q <= shift_q;
    end
  end

  assign bus.Data_Sample_EN = dse;
  assign bus.Edge_Counter   = edge_cnt;
  assign bus.P_DATA         = pdata_q;
  assign bus.data_valid     = dv_q;
  assign bus.Parity_Error   = perr_q;
  assign bus.Stop_Error     = serr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames are built from bit lists, expected
// P_DATA and arrival cycle are queued at send time and matched by a monitor.
module tb_uart_rx_ctrl;
  localparam int DW = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  uart_rx_ctrl_if #(.DATA_WIDTH(DW)) bus ();
  uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  // Idealised sampler: the vote result is only meaningful at the capture edge,
  // elsewhere it presents the wrong value so a mistimed capture shows up.
  int cap_m = 99;
  assign bus.Sampled_bit = (int'(bus.Edge_Counter) == cap_m) ? bus.RX_IN : ~bus.RX_IN;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] data; int at; } exp_t;
  exp_t sb[$];
  logic [DW-1:0] last_good = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge CLK) begin
    #1;
    if (bus.data_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL dv_unexpected: got data_valid with P_DATA %0h want none (cyc %0d)", bus.P_DATA, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("dv_data", 32'(bus.P_DATA), 32'(e.data));
        check("dv_time", cyc, e.at);
      end
    end
  end

  function automatic int eff_p(input int p);
    return (p == 4 || p == 8 || p == 16 || p == 32) ? p : 8;
  endfunction

  function automatic int cap_of(input int p);
    return (p == 4) ? 2 : p / 2 + 2;
  endfunction

  task automatic idle_checks(input string tag, input bit perr, input bit serr);
    check({tag, "_dse"},  32'(bus.Data_Sample_EN), 0);
    check({tag, "_ec"},   32'(bus.Edge_Counter), 0);
    check({tag, "_perr"}, 32'(bus.Parity_Error), 32'(perr));
    check({tag, "_serr"}, 32'(bus.Stop_Error), 32'(serr));
    check({tag, "_pdat"}, 32'(bus.P_DATA), 32'(last_good));
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input int pin_p, input bit pe, input bit pt,
                            input bit bad_par, input bit stop_bit, input int gap, input bit scramble);
    int p, det, nbits;
    bit perr, serr;
    logic fb[$];
    p     = eff_p(pin_p);
    perr  = pe && bad_par;
    serr  = !stop_bit;
    nbits = 2 + DW + (pe ? 1 : 0);
    fb.push_back(1'b0);
    for (int i = 0; i < DW; i++) fb.push_back(d[i]);
    if (pe) fb.push_back((^d) ^ pt ^ bad_par);
    fb.push_back(stop_bit);

    bus.prescaler = 6'(pin_p);
    bus.PAR_EN    = pe;
    bus.PAR_TYP   = pt;
    cap_m         = cap_of(p);
    det           = cyc + 1;
    if (!perr && !serr) sb.push_back('{d, det + nbits * p});

    for (int i = 0; i < nbits; i++) begin
      bus.RX_IN = fb[i];
      for (int k = 0; k < p; k++) begin
        if (i == 0 && k == 1) begin
          check("start_dse",  32'(bus.Data_Sample_EN), 1);
          check("start_ec",   32'(bus.Edge_Counter), 0);
          check("start_perr", 32'(bus.Parity_Error), 0);
          check("start_serr", 32'(bus.Stop_Error), 0);
        end
        if (scramble && i == 1 && k == 0) begin
          bus.prescaler = 6'($urandom);
          bus.PAR_EN    = ~pe;
          bus.PAR_TYP   = ~pt;
        end
        @(negedge CLK);
      end
    end
    bus.RX_IN     = 1'b1;
    bus.prescaler = 6'(pin_p);
    bus.PAR_EN    = pe;
    bus.PAR_TYP   = pt;
    if (!perr && !serr) last_good = d;
    repeat (gap) @(negedge CLK);
    if (gap >= 2) idle_checks("post", perr, serr);
  endtask

  int pin_p;
  bit pe, pt, bp, sbit;
  int gap, prev_gap;

  initial begin
    bus.RX_IN = 1'b1; bus.prescaler = 6'd8; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
    repeat (3) @(negedge CLK);
    idle_checks("reset", 1'b0, 1'b0);
    check("reset_dv", 32'(bus.data_valid), 0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    send_frame(8'hA5, 8, 0, 0, 0, 1, 3, 0);
    send_frame(8'h3C, 16, 1, 0, 0, 1, 3, 0);
    send_frame(8'h3C, 16, 1, 0, 1, 1, 3, 0);
    send_frame(8'hFF, 4, 0, 0, 0, 0, 3, 0);
    send_frame(8'h96, 4, 1, 1, 0, 1, 3, 0);

    // Start glitch: line low two cycles, rejected at capture edge 6.
    bus.prescaler = 6'd8; bus.PAR_EN = 1'b0; cap_m = 6;
    bus.RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    bus.RX_IN = 1'b1;
    repeat (5) @(negedge CLK);
    check("glitch_dse_hi", 32'(bus.Data_Sample_EN), 1);
    check("glitch_ec6",    32'(bus.Edge_Counter), 6);
    @(negedge CLK);
    idle_checks("glitch", 1'b0, 1'b0);
    repeat (3) @(negedge CLK);

    send_frame(8'h12, 8, 0, 0, 0, 1, 0, 0);
    send_frame(8'h34, 8, 0, 0, 0, 1, 3, 0);
    send_frame(8'h81, 5, 1, 1, 0, 1, 3, 1);

    // Reset in the middle of the data bits.
    bus.prescaler = 6'd8; bus.PAR_EN = 1'b0; cap_m = 6;
    bus.RX_IN = 1'b0;
    repeat (8) @(negedge CLK);
    bus.RX_IN = 1'b1; repeat (8) @(negedge CLK);
    bus.RX_IN = 1'b1; repeat (8) @(negedge CLK);
    bus.RX_IN = 1'b0; repeat (8) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1; bus.RX_IN = 1'b1;
    last_good = '0;
    idle_checks("midrst", 1'b0, 1'b0);
    check("midrst_dv", 32'(bus.data_valid), 0);
    repeat (3) @(negedge CLK);
    send_frame(8'h5A, 8, 0, 0, 0, 1, 3, 0);

    prev_gap = 3;
    for (int n = 0; n < 30; n++) begin
      if (prev_gap != 0) begin
        case ($urandom_range(0, 4))
          0: pin_p = 4;
          1: pin_p = 8;
          2: pin_p = 16;
          3: pin_p = 32;
          default: pin_p = ($urandom_range(0, 1) != 0) ? 12 : 0;
        endcase
        pe = 1'($urandom);
        pt = 1'($urandom);
      end
      bp   = ($urandom_range(0, 5) == 0);
      sbit = ($urandom_range(0, 5) != 0);
      gap  = ((pe && bp) || !sbit) ? int'($urandom_range(2, 4)) : int'($urandom_range(0, 3));
      send_frame(8'($urandom), pin_p, pe, pt, bp, sbit, gap, 1'($urandom));
      prev_gap = gap;
    end

    repeat (10) @(negedge CLK);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
